// File: rtl/atm_pkg.sv
// Shared ATM front-end constants: key codes, 7-seg display codes, entry field states.
package atm_pkg;

  localparam logic [7:0] KEY_BS    = 8'h08;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_0     = 8'h30;
  localparam logic [7:0] KEY_9     = 8'h39;

  localparam logic [3:0] SEG_BLANK = 4'hF;
  localparam logic [3:0] SEG_DASH  = 4'hE;

  typedef enum logic [1:0] {
    StEntry,
    StConvert,
    StPresent
  } entry_state_e;

  function automatic logic is_digit(input logic [7:0] code);
    return (code >= KEY_0) && (code <= KEY_9);
  endfunction

endpackage

// File: rtl/bcd_digit_stack.sv
// BCD digit stack: new digits enter at the right (nibble 0), backspace drops the rightmost.
module bcd_digit_stack #(
  parameter int unsigned MaxDigits = 4,
  localparam int unsigned CntW     = $clog2(MaxDigits + 1),
  localparam int unsigned StackW   = 4 * MaxDigits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [3:0]        digit_i,
  output logic [StackW-1:0] stack_o,
  output logic [CntW-1:0]   count_o
);

  logic [StackW-1:0] stack_q, stack_d;
  logic [CntW-1:0]   count_q, count_d;

  // Next stack contents; caller guarantees push only below capacity, pop only when non-empty.
  always_comb begin
    stack_d = stack_q;
    count_d = count_q;
    if (clr_i) begin
      stack_d = '0;
      count_d = '0;
    end else if (push_i) begin
      stack_d = (stack_q << 4) | StackW'(digit_i);
      count_d = count_q + 1'b1;
    end else if (pop_i) begin
      stack_d = stack_q >> 4;
      count_d = count_q - 1'b1;
    end
  end

  // Stack and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q <= '0;
      count_q <= '0;
    end else begin
      stack_q <= stack_d;
      count_q <= count_d;
    end
  end

  assign stack_o = stack_q;
  assign count_o = count_q;

endmodule

// File: rtl/numeric_entry_field.sv
// Keyboard numeric entry field: digit collection, display image, timeout, BCD-to-binary result.
module numeric_entry_field
  import atm_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 4,
  parameter int unsigned VAL_W       = 16,
  parameter int unsigned MASK_EN     = 0,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000,
  localparam int unsigned CntW       = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              ascii_in,
  input  logic                    ascii_valid,
  input  logic                    enable,
  input  logic                    clear,
  output logic [VAL_W-1:0]        val_out,
  output logic                    val_sat,
  output logic                    val_valid,
  input  logic                    val_ready,
  output logic [CntW-1:0]         digit_count,
  output logic [4*MAX_DIGITS-1:0] disp_bcd,
  output logic                    busy,
  output logic                    err_pulse,
  output logic                    timeout
);

  localparam int unsigned StackW = 4 * MAX_DIGITS;
  localparam int unsigned AccW   = VAL_W + 4;
  localparam int unsigned IdleW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  entry_state_e      state_q, state_d;
  logic [CntW-1:0]   count;
  logic [StackW-1:0] stack;
  logic              stk_clr, stk_push, stk_pop;
  logic [CntW-1:0]   pos_q, pos_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic              sat_q, sat_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [IdleW-1:0]  idle_q, idle_d;

  logic              key_act, key_taken, full;
  logic [CntW-1:0]   pos_idx;
  logic [StackW-1:0] digit_shift;
  logic [3:0]        cur_digit;
  logic [AccW-1:0]   acc_mul;

  bcd_digit_stack #(
    .MaxDigits(MAX_DIGITS)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (stk_clr),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .digit_i(ascii_in[3:0]),
    .stack_o(stack),
    .count_o(count)
  );

  assign key_act = (state_q == StEntry) && enable && ascii_valid;
  assign full    = (count == CntW'(MAX_DIGITS));

  // Converter reads the digit at pos_q-1, walking from the most significant digit down.
  assign pos_idx     = pos_q - 1'b1;
  assign digit_shift = stack >> {pos_idx, 2'b00};
  assign cur_digit   = digit_shift[3:0];
  assign acc_mul     = (acc_q << 3) + (acc_q << 1) + AccW'(cur_digit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEntry;
    else        state_q <= state_d;
  end

  // Next-state logic; clear aborts from any state.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StEntry;
    end else begin
      unique case (state_q)
        StEntry:   if (key_act && ascii_in == KEY_ENTER && count != '0) state_d = StConvert;
        StConvert: if (pos_q == '0) state_d = StPresent;
        StPresent: if (val_ready) state_d = StEntry;
        default:   state_d = StEntry;
      endcase
    end
  end

  // Datapath next values: key handling, idle timeout, conversion and result handshake.
  always_comb begin
    stk_clr   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    key_taken = 1'b0;
    pos_d     = pos_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    val_d     = val_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    idle_d    = idle_q;
    if (clear) begin
      stk_clr = 1'b1;
      valid_d = 1'b0;
      idle_d  = '0;
    end else begin
      unique case (state_q)
        StEntry: begin
          if (key_act) begin
            if (is_digit(ascii_in)) begin
              if (full) err_d = 1'b1;
              else begin
                stk_push  = 1'b1;
                key_taken = 1'b1;
              end
            end else if (ascii_in == KEY_BS) begin
              stk_pop   = (count != '0);
              key_taken = 1'b1;
            end else if (ascii_in == KEY_ESC) begin
              stk_clr   = 1'b1;
              key_taken = 1'b1;
            end else if (ascii_in == KEY_ENTER && count != '0) begin
              pos_d     = count;
              acc_d     = '0;
              ovf_d     = 1'b0;
              key_taken = 1'b1;
            end
          end
          if (key_taken || !enable || count == '0 || TIMEOUT_CYC == 0) begin
            idle_d = '0;
          end else if (idle_q == IdleW'(TIMEOUT_CYC - 1)) begin
            stk_clr = 1'b1;
            tmo_d   = 1'b1;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        StConvert: begin
          if (pos_q != '0) begin
            pos_d = pos_q - 1'b1;
            // Once overflowed the accumulator is frozen; only the sticky flag matters.
            if (!ovf_q) begin
              if (|acc_mul[AccW-1:VAL_W]) ovf_d = 1'b1;
              else                        acc_d = acc_mul;
            end
          end else begin
            val_d   = ovf_q ? '1 : acc_q[VAL_W-1:0];
            sat_d   = ovf_q;
            valid_d = 1'b1;
          end
        end
        StPresent: begin
          if (val_ready) begin
            valid_d = 1'b0;
            stk_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      val_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
    end
  end

  // Outputs and display image; the stack is frozen outside ENTRY so the display holds too.
  always_comb begin
    val_out     = val_q;
    val_sat     = sat_q;
    val_valid   = valid_q;
    digit_count = count;
    busy        = (state_q != StEntry);
    err_pulse   = err_q;
    timeout     = tmo_q;
    disp_bcd    = '1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (i < int'(count)) disp_bcd[4*i +: 4] = (MASK_EN != 0) ? SEG_DASH : stack[4*i +: 4];
      else                 disp_bcd[4*i +: 4] = SEG_BLANK;
    end
  end

endmodule
